// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue and frame sequencer feeding the UART transmitter.
//   Host pushes bytes into a circular FIFO. Each byte is framed as
//   {stop=1, data[7:0], start=0} and handed to the transmitter one frame at a
//   time over the tx_en / tx_Busy / tx_Done handshake.
//
// Handshake semantics (host side and transmitter side):
//   - wr_en is a one-cycle push request. It is accepted when the FIFO is not
//     full, or when it is full and a pop happens in the same cycle. Otherwise
//     the byte is dropped and overflow is set.
//   - A pop happens only on the IDLE->SEND transition: FIFO not empty and
//     tx_Busy low. txin_data is loaded on that edge and is then held until
//     the next such edge.
//   - tx_en is high for exactly the SEND state. tx_Done (a one-cycle pulse)
//     completes the frame from SEND or WAIT_DONE, and sent pulses once for it.
//     tx_Done seen in IDLE is ignored.
//
// Optional feature macro: UART_TXQ_DROP_CNT_EN
//   When defined, adds drop_cnt[7:0], a saturating count of dropped pushes,
//   and overflow becomes (drop_cnt != 0).
//
// state_dbg encoding: 2'd0 IDLE, 2'd1 SEND, 2'd2 WAIT_DONE.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          fifo_rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          tx_en,
   output logic [9:0]    txin_data,
   input  logic          tx_Busy,
   input  logic          tx_Done,
   output logic          sent,
`ifdef UART_TXQ_DROP_CNT_EN
   output logic [7:0]    drop_cnt,
`endif
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_e;

   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [9:0]    IDLE_LINE  = 10'h3FF;

   // storage
   logic [7:0]    mem_q [DEPTH];

   // state
   state_e        state_q,   state_d;
   logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
   logic [AW:0]   count_q,   count_d;
   logic          full_q,    full_d;
   logic          empty_q,   empty_d;
   logic          tx_en_q,   tx_en_d;
   logic [9:0]    txin_q,    txin_d;
   logic          sent_q,    sent_d;
`ifdef UART_TXQ_DROP_CNT_EN
   logic [7:0]    drop_cnt_q, drop_cnt_d;
`else
   logic          overflow_q, overflow_d;
`endif

   // per-cycle FIFO events
   logic          pop;
   logic          push;
   logic          drop;

   // Decide this cycle's pop, accepted push and dropped push.
   always_comb begin
      pop  = (state_q == S_IDLE) && !empty_q && !tx_Busy;
      push = wr_en && (!full_q || pop);
      drop = wr_en && full_q && !pop;
   end

   // Next-state for pointers, occupancy, flags, framer FSM and its outputs.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      txin_d   = txin_q;
      sent_d   = 1'b0;
`ifdef UART_TXQ_DROP_CNT_EN
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
`else
      overflow_d = overflow_q | drop;
`endif

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == FULL_COUNT);
      empty_d = (count_d == '0);

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               txin_d  = {1'b1, mem_q[rd_ptr_q], 1'b0};
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            // A fast transmitter may finish before ever raising tx_Busy.
            if (tx_Done) begin
               state_d = S_IDLE;
               sent_d  = 1'b1;
            end else if (tx_Busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (tx_Done) begin
               state_d = S_IDLE;
               sent_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      tx_en_d = (state_d == S_SEND);
   end

   // Register all control state; reset abandons the queue and any frame.
   always_ff @(posedge clk) begin
      if (fifo_rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         tx_en_q  <= 1'b0;
         txin_q   <= IDLE_LINE;
         sent_q   <= 1'b0;
`ifdef UART_TXQ_DROP_CNT_EN
         drop_cnt_q <= 8'd0;
`else
         overflow_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         tx_en_q  <= tx_en_d;
         txin_q   <= txin_d;
         sent_q   <= sent_d;
`ifdef UART_TXQ_DROP_CNT_EN
         drop_cnt_q <= drop_cnt_d;
`else
         overflow_q <= overflow_d;
`endif
      end
   end

   // Write accepted bytes into storage; the read for a same-cycle pop sees
   // the old contents, so push-while-full at rd_ptr is safe.
   always_ff @(posedge clk) begin
      if (!fifo_rst && push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;
   assign tx_en     = tx_en_q;
   assign txin_data = txin_q;
   assign sent      = sent_q;
   assign state_dbg = state_q;
`ifdef UART_TXQ_DROP_CNT_EN
   assign drop_cnt  = drop_cnt_q;
   assign overflow  = (drop_cnt_q != 8'd0);
`else
   assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based
// reference model compared against the DUT every cycle, plus literal checks.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   localparam int P_IDLE = 0;
   localparam int P_SEND = 1;
   localparam int P_WAIT = 2;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          fifo_rst = 1'b1;
   logic          wr_en    = 1'b0;
   logic [7:0]    wr_data  = 8'h00;
   logic          tx_Busy  = 1'b0;
   logic          tx_Done  = 1'b0;
   logic          full, empty, overflow, tx_en, sent;
   logic [AW:0]   count;
   logic [9:0]    txin_data;
   logic [1:0]    state_dbg;
`ifdef UART_TXQ_DROP_CNT_EN
   logic [7:0]    drop_cnt;
`endif

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .fifo_rst  (fifo_rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .tx_en     (tx_en),
      .txin_data (txin_data),
      .tx_Busy   (tx_Busy),
      .tx_Done   (tx_Done),
      .sent      (sent),
`ifdef UART_TXQ_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .state_dbg (state_dbg)
   );

   // counters
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // reference model: queue of bytes plus frame phase
   logic [7:0] m_q[$];
   int         m_phase = P_IDLE;
   logic [9:0] m_word  = 10'h3FF;
   bit         m_sent  = 1'b0;
   bit         m_ovf   = 1'b0;
   int         m_drops = 0;
   bit         m_pop, m_push;
   logic [7:0] m_byte;

   initial forever begin
      @(posedge clk);
      if (fifo_rst) begin
         m_q.delete();
         m_phase = P_IDLE;
         m_word  = 10'h3FF;
         m_sent  = 1'b0;
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         m_pop  = (m_phase == P_IDLE) && (m_q.size() > 0) && !tx_Busy;
         m_push = wr_en && ((m_q.size() < DEPTH) || m_pop);
         m_sent = 1'b0;
         if (wr_en && !m_push) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
         if (m_pop) begin
            m_byte  = m_q.pop_front();
            m_word  = {1'b1, m_byte, 1'b0};
            m_phase = P_SEND;
         end else if (m_phase == P_SEND && tx_Done) begin
            m_phase = P_IDLE;
            m_sent  = 1'b1;
         end else if (m_phase == P_SEND && tx_Busy) begin
            m_phase = P_WAIT;
         end else if (m_phase == P_WAIT && tx_Done) begin
            m_phase = P_IDLE;
            m_sent  = 1'b1;
         end
         if (m_push) m_q.push_back(wr_data);
      end
   end

   // per-cycle compare against the model
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         check("count",     32'(count),     32'(m_q.size()));
         check("empty",     32'(empty),     32'(m_q.size() == 0));
         check("full",      32'(full),      32'(m_q.size() == DEPTH));
         check("tx_en",     32'(tx_en),     32'(m_phase == P_SEND));
         check("txin_data", 32'(txin_data), 32'(m_word));
         check("sent",      32'(sent),      32'(m_sent));
         check("state",     32'(state_dbg), 32'(m_phase));
`ifdef UART_TXQ_DROP_CNT_EN
         check("drop_cnt",  32'(drop_cnt),  32'(m_drops));
         check("overflow",  32'(overflow),  32'(m_drops != 0));
`else
         check("overflow",  32'(overflow),  32'(m_ovf));
`endif
      end
   end

   // driver tasks
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   task automatic do_reset();
      fifo_rst = 1'b1; wr_en = 1'b0; tx_Busy = 1'b0; tx_Done = 1'b0;
      tick();
      fifo_rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      tick();
      wr_en = 1'b0;
   endtask

   // Slow transmitter: busy for two cycles after tx_en, then a done pulse.
   task automatic drain(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         tx_Busy = 1'b0;
         k = 0;
         while (!tx_en && k < 40) begin tick(); k++; end
         if (!tx_en) begin
            check("drain_tx_en_timeout", 32'(tx_en), 32'd1);
            return;
         end
         got_q.push_back(txin_data[8:1]);
         tx_Busy = 1'b1; tick(); tick();
         tx_Busy = 1'b0; tx_Done = 1'b1; tick();
         tx_Done = 1'b0;
      end
   endtask

   task automatic score(input string name);
      check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check(name, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      // reset state
      tick(); tick();
      cmp_en = 1'b1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_txin",  32'(txin_data), 32'h3FF);
      check("rst_tx_en", 32'(tx_en), 32'd0);
      fifo_rst = 1'b0;
      tick();

      // single byte A5, two-cycle latency, busy then done
      push(8'hA5);
      check("a5_store_tx_en", 32'(tx_en), 32'd0);
      check("a5_store_count", 32'(count), 32'd1);
      tick();
      check("a5_tx_en", 32'(tx_en), 32'd1);
      check("a5_frame", 32'(txin_data), 32'h34A);   // {stop, A5, start}
      tx_Busy = 1'b1; tick();
      check("a5_wait_tx_en", 32'(tx_en), 32'd0);
      tx_Busy = 1'b0; tx_Done = 1'b1; tick();
      tx_Done = 1'b0;
      check("a5_sent", 32'(sent), 32'd1);
      check("a5_empty", 32'(empty), 32'd1);
      check("a5_idle", 32'(state_dbg), 32'd0);
      tick();
      check("a5_sent_pulse", 32'(sent), 32'd0);
      check("a5_frame_kept", 32'(txin_data), 32'h34A);

      // fill while stalled, overflow, ordered drain
      tx_Busy = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i));
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd16);
      push(8'hFF);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
      drain(16);
      score("drain_order");
      tick();
      check("drain_empty", 32'(empty), 32'd1);

      // push accepted while full because a pop happens the same cycle
      do_reset();
      tx_Busy = 1'b1;
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      tx_Busy = 1'b0;
      push(8'h3C);
      check("pp_count", 32'(count), 32'd16);
      check("pp_overflow", 32'(overflow), 32'd0);
      check("pp_tx_en", 32'(tx_en), 32'd1);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
      exp_q.push_back(8'h3C);
      drain(17);
      score("pp_order");

      // fast transmitter: done right after tx_en, no busy
      do_reset();
      push(8'h55);
      push(8'hAA);
      check("fast_frame0", 32'(txin_data), 32'h2AA);
      tx_Done = 1'b1; tick();
      tx_Done = 1'b0;
      check("fast_sent", 32'(sent), 32'd1);
      check("fast_idle", 32'(state_dbg), 32'd0);
      tick();
      check("fast_next_tx_en", 32'(tx_en), 32'd1);
      check("fast_frame1", 32'(txin_data), 32'h354);
      tx_Done = 1'b1; tick();
      tx_Done = 1'b0;
      check("fast_sent1", 32'(sent), 32'd1);
      tick();

      // reset while in WAIT_DONE with five bytes queued
      push(8'h01);
      push(8'h02);
      tx_Busy = 1'b1;
      for (int i = 3; i <= 6; i++) push(8'(i));
      check("mid_count", 32'(count), 32'd5);
      check("mid_state", 32'(state_dbg), 32'd2);
      fifo_rst = 1'b1; tick();
      fifo_rst = 1'b0;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_tx_en", 32'(tx_en), 32'd0);
      check("mid_rst_txin", 32'(txin_data), 32'h3FF);
      tx_Busy = 1'b0; tx_Done = 1'b1; tick();
      tx_Done = 1'b0;
      check("mid_no_sent", 32'(sent), 32'd0);
      tick();

`ifdef UART_TXQ_DROP_CNT_EN
      // saturating drop counter
      do_reset();
      tx_Busy = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i));
      wr_en = 1'b1; wr_data = 8'hEE;
      for (int i = 0; i < 300; i++) tick();
      wr_en = 1'b0;
      check("drop_sat", 32'(drop_cnt), 32'hFF);
      check("drop_ovf", 32'(overflow), 32'd1);
      check("drop_count", 32'(count), 32'd16);
      tx_Busy = 1'b0;
      do_reset();
      tick();
`endif

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
